// File: rtl/ifetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ifetch_buffer
//  Description : Y86-64 instruction prefetch buffer. Streams bytes from a
//                byte-wide instruction memory into a circular byte queue,
//                decodes the head icode for instruction length and presents
//                one complete instruction (up to 10 bytes) with its PC.
//                A redirect flushes the queue and refetches from a new PC.
//  Ports       : clk, rst_n           clock, async active-low reset
//                mem_req/addr/ready   byte read request channel
//                mem_rvalid/rdata     byte read response channel
//                inst_valid/pc/bytes/len/err  head instruction to fetch
//                inst_ready           fetch consumes the head instruction
//                redirect/redirect_pc flush and restart at a new PC
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    output logic [63:0] inst_pc,
    output logic [79:0] inst_bytes,
    output logic [3:0]  inst_len,
    output logic        inst_err,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

    state_t             r_state;
    logic [7:0]         r_queue [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;
    logic [63:0]        r_fetch_addr;
    logic [63:0]        r_inst_pc;

    logic [7:0]         w_byte0;
    logic [3:0]         w_len;
    logic               w_err;
    logic [PTR_W:0]     w_len_cnt;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;

    assign w_byte0 = r_queue[r_head];

    // Length decode on the head icode; undefined icodes are 1 byte + error.
    always_comb begin
        w_len = 4'd1;
        w_err = 1'b0;
        case (w_byte0[7:4])
            4'h0, 4'h1, 4'h9:        w_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:  w_len = 4'd2;
            4'h7, 4'h8:              w_len = 4'd9;
            4'h3, 4'h4, 4'h5:        w_len = 4'd10;
            default: begin
                w_len = 4'd1;
                w_err = 1'b1;
            end
        endcase
    end

    assign w_len_cnt  = {{(PTR_W-3){1'b0}}, w_len};

    assign mem_req    = (r_state == S_REQ) && (r_count < c_full);
    assign mem_addr   = r_fetch_addr;
    assign inst_valid = (r_count >= w_len_cnt);
    assign inst_pc    = r_inst_pc;
    assign inst_len   = w_len;
    assign inst_err   = w_err;

    assign w_accept   = mem_req && mem_ready;
    assign w_pop      = inst_valid && inst_ready && !redirect;
    assign w_push     = (r_state == S_WAIT) && mem_rvalid && !redirect;

    // Head window: byte k of the head instruction, wrapping around the queue.
    for (genvar k = 0; k < 10; k++) begin : g_bytes
        assign inst_bytes[8*k +: 8] = r_queue[r_head + PTR_W'(k)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fetch_addr <= '0;
            r_inst_pc    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_queue[i] <= '0;
            end
        end else if (redirect) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fetch_addr <= redirect_pc;
            r_inst_pc    <= redirect_pc;
            // An accepted request whose data has not yet returned must be
            // drained and dropped before issuing at the new address. A
            // response landing in this same cycle closes the transaction.
            case (r_state)
                S_IDLE:    r_state <= S_REQ;
                S_REQ:     r_state <= w_accept ? S_DISCARD : S_REQ;
                S_WAIT:    r_state <= mem_rvalid ? S_REQ : S_DISCARD;
                S_DISCARD: r_state <= mem_rvalid ? S_REQ : S_DISCARD;
                default:   r_state <= S_IDLE;
            endcase
        end else begin
            if (w_push) begin
                r_queue[r_tail] <= mem_rdata;
                r_tail          <= r_tail + 1'b1;
                r_fetch_addr    <= r_fetch_addr + 64'd1;
            end
            if (w_pop) begin
                r_head    <= r_head + PTR_W'(w_len);
                r_inst_pc <= r_inst_pc + 64'(w_len);
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push}
                               - (w_pop ? w_len_cnt : '0);
            case (r_state)
                S_IDLE:    r_state <= S_REQ;
                S_REQ:     if (w_accept)   r_state <= S_WAIT;
                S_WAIT:    if (mem_rvalid) r_state <= S_REQ;
                S_DISCARD: if (mem_rvalid) r_state <= S_REQ;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_buffer
//  Description : Self-checking bench for ifetch_buffer. A byte memory model
//                with programmable latency answers requests; expected
//                instructions are parsed from the memory image into a
//                scoreboard and compared as fetch consumes them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic [79:0] inst_bytes;
    logic [3:0]  inst_len;
    logic        inst_err;
    logic        inst_ready;
    logic        redirect;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    ifetch_buffer #(.DEPTH(16), .PTR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .inst_bytes  (inst_bytes),
        .inst_len    (inst_len),
        .inst_err    (inst_err),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  len;
        logic [79:0] bytes;
        logic        err;
    } exp_t;

    logic [7:0]  mem [256];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    int          resp_cnt = 0;
    int          mem_lat = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_len(input logic [7:0] b);
        case (b[7:4])
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    // Parse n instructions from the memory image starting at pc.
    task automatic expect_stream(input logic [63:0] pc, input int n);
        exp_t e;
        logic [63:0] p;
        p = pc;
        for (int i = 0; i < n; i++) begin
            e.pc    = p;
            e.len   = ref_len(mem[p[7:0]]);
            e.err   = (mem[p[7:0]][7:4] > 4'hB);
            e.bytes = '0;
            for (int k = 0; k < 10; k++) begin
                if (k < int'(e.len)) e.bytes[8*k +: 8] = mem[8'(p + 64'(k))];
            end
            sb.push_back(e);
            p = p + 64'(e.len);
        end
    endtask

    // Memory model: one outstanding request, response after mem_lat idle cycles.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem[pend_addr[7:0]];
                        pend       = 1'b0;
                        resp_cnt++;
                    end else begin
                        pend_cnt--;
                    end
                end
                if (mem_req && mem_ready) begin
                    pend      = 1'b1;
                    pend_cnt  = mem_lat;
                    pend_addr = mem_addr;
                end
            end
        end
    end

    // Consumption monitor: compare every instruction taken by fetch.
    initial begin
        exp_t e;
        logic [79:0] m;
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready && !redirect) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 80'(sb.size()), 80'd1);
                end else begin
                    e = sb.pop_front();
                    m = '0;
                    for (int k = 0; k < 10; k++) begin
                        if (k < int'(e.len)) m[8*k +: 8] = 8'hFF;
                    end
                    chk("sb_pc",    80'(inst_pc),     80'(e.pc));
                    chk("sb_len",   80'(inst_len),    80'(e.len));
                    chk("sb_bytes", inst_bytes & m,   e.bytes);
                    chk("sb_err",   80'(inst_err),    80'(e.err));
                end
                consumed++;
            end
        end
    end

    task automatic run_until(input int target);
        int cyc;
        cyc = 0;
        inst_ready = 1'b1;
        while (consumed < target && cyc < 300) begin
            @(posedge clk); #1;
            if (consumed >= target) inst_ready = 1'b0;
            cyc++;
        end
        inst_ready = 1'b0;
        chk("consume_count", 80'(consumed), 80'(target));
    endtask

    task automatic wait_req(input string tag);
        int cyc;
        cyc = 0;
        while (!mem_req && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(tag, 80'(mem_req), 80'd1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        mem[0] = 8'h10;  mem[1] = 8'h00;
        mem[2] = 8'h30;  mem[3] = 8'hF3;
        for (int i = 4; i < 12; i++) mem[i] = 8'(i - 3);
        mem[12] = 8'hD0;
        mem[8'h40] = 8'h60; mem[8'h41] = 8'h12;
        mem[8'h42] = 8'h70;
        for (int i = 8'h43; i < 8'h4B; i++) mem[i] = 8'(i);
        mem[8'h4B] = 8'h10;

        mem_ready   = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req",    80'(mem_req),    80'd0);
        chk("rst_mem_addr",   80'(mem_addr),   80'd0);
        chk("rst_inst_valid", 80'(inst_valid), 80'd0);
        chk("rst_inst_len",   80'(inst_len),   80'd1);
        chk("rst_inst_bytes", inst_bytes,      80'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        wait_req("first_req");
        chk("first_req_addr", 80'(mem_addr), 80'd0);

        // Two single-byte instructions at 0 and 1
        expect_stream(64'd0, 2);
        run_until(2);

        // irmovq: valid only once all ten bytes are in
        cyc = 0;
        while (!inst_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("irm_valid",    80'(inst_valid),       80'd1);
        chk("irm_pushes",   80'(resp_cnt),         80'd12);
        chk("irm_len",      80'(inst_len),         80'd10);
        chk("irm_byte1",    80'(inst_bytes[15:8]), 80'hF3);
        chk("irm_pc",       80'(inst_pc),          80'd2);

        // Pop the irmovq on the same edge that pushes the next byte
        @(posedge clk); #1;
        expect_stream(64'd2, 1);
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
        chk("pp_push",      80'(resp_cnt),   80'd13);
        chk("pp_consumed",  80'(consumed),   80'd3);
        chk("pp_valid",     80'(inst_valid), 80'd1);
        chk("pp_pc",        80'(inst_pc),    80'd12);
        chk("err_flag",     80'(inst_err),   80'd1);
        chk("err_len",      80'(inst_len),   80'd1);

        // Fill to capacity with fetch stalled
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("full_resp",    80'(resp_cnt), 80'd28);
        chk("full_no_req",  80'(mem_req),  80'd0);
        expect_stream(64'd12, 1);
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
        chk("unfull_req",   80'(mem_req),  80'd1);
        chk("unfull_addr",  80'(mem_addr), 80'd28);

        // Request held while memory is not ready
        mem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("hold_req",  80'(mem_req),  80'd1);
        chk("hold_addr", 80'(mem_addr), 80'd28);

        // Redirect to 0x40 while a slow response is outstanding
        mem_lat   = 3;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("redir_no_req", 80'(mem_req),    80'd0);
        chk("redir_pc",     80'(inst_pc),    80'h40);
        chk("redir_valid",  80'(inst_valid), 80'd0);
        wait_req("redir_req");
        chk("redir_addr",   80'(mem_addr),   80'h40);
        mem_lat = 0;
        expect_stream(64'h40, 3);
        run_until(7);

        // Asynchronous reset in the middle of a transaction
        mem_lat = 3;
        wait_req("pre_rst_req");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req",    80'(mem_req),    80'd0);
        chk("arst_mem_addr",   80'(mem_addr),   80'd0);
        chk("arst_inst_valid", 80'(inst_valid), 80'd0);
        chk("arst_inst_pc",    80'(inst_pc),    80'd0);
        chk("arst_inst_len",   80'(inst_len),   80'd1);
        chk("arst_inst_err",   80'(inst_err),   80'd0);
        chk("arst_inst_bytes", inst_bytes,      80'd0);
        @(negedge clk); #1;
        sb.delete();
        mem_lat = 0;
        rst_n = 1'b1;
        chk("rel_no_req", 80'(mem_req), 80'd0);
        wait_req("rel_req");
        chk("rel_addr", 80'(mem_addr), 80'd0);
        expect_stream(64'd0, 2);
        run_until(9);

        chk("sb_empty", 80'(sb.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
